// File: rtl/pcm_tdm_decoder.sv
// pcm_tdm_decoder: serial A-law PCM TDM expander.
// Deserialises an MSB-first bitstream that is qualified by bit_en and aligned to frame_sync.
// Codes are distributed over NUM_CH slots and expanded to 13-bit sign-magnitude linear form.
// The top OUT_W bits of the linear value are emitted, tagged with the channel index.
// The block tracks frame lock and flags misplaced frame_sync pulses.
// Optional feature macro: ALAW_EVEN_INVERT_EN. When it is defined, each assembled code is
// XORed with 8'h55 (G.711 even-bit inversion) before expansion.
module pcm_tdm_decoder #(
    parameter int NUM_CH        = 4,
    parameter int OUT_W         = 8,
    parameter int SYNC_MISS_MAX = 2,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic             frame_sync,
    output logic             pcm_valid,
    output logic [OUT_W-1:0] pcm_out,
    output logic [CH_W-1:0]  pcm_ch,
    output logic [7:0]       code_out,
    output logic             locked,
    output logic             slip_err
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

`ifdef ALAW_EVEN_INVERT_EN
    localparam logic [7:0] INV_MASK = 8'h55;
`else
    localparam logic [7:0] INV_MASK = 8'h00;
`endif

    state_t             state_q, state_d;
    logic [6:0]         shreg_q, shreg_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [CH_W-1:0]    ch_cnt_q, ch_cnt_d;
    logic [2:0]         miss_cnt_q, miss_cnt_d;
    logic               pcm_valid_q, pcm_valid_d;
    logic [OUT_W-1:0]   pcm_out_q, pcm_out_d;
    logic [CH_W-1:0]    pcm_ch_q, pcm_ch_d;
    logic [7:0]         code_out_q, code_out_d;
    logic               locked_q, locked_d;
    logic               slip_err_q, slip_err_d;

    logic [7:0]         word_raw;
    logic [7:0]         word_code;
    logic [12:0]        word_lin;
    logic               at_sync_pt;
    logic               miss_limit;

    // A-law expansion to 13-bit sign-magnitude: segment 0 is linear and
    // higher segments place the pattern 1,m,1 shifted up by seg-1.
    function automatic logic [12:0] alaw_expand(input logic [7:0] c);
        logic [2:0]  seg;
        logic [3:0]  m;
        logic [11:0] mag;
        seg = c[6:4];
        m   = c[3:0];
        if (seg == 3'd0) begin
            mag = {7'b0, m, 1'b1};
        end else begin
            mag = {6'b0, 1'b1, m, 1'b1} << (seg - 3'd1);
        end
        return {c[7], mag};
    endfunction

    // The current bit completes the word formed by the seven held bits.
    assign word_raw   = {shreg_q, bit_in};
    assign word_code  = word_raw ^ INV_MASK;
    assign word_lin   = alaw_expand(word_code);
    assign at_sync_pt = (bit_cnt_q == 3'd0) && (ch_cnt_q == '0);
    assign miss_limit = ({1'b0, miss_cnt_q} + 4'd1) >= 4'(SYNC_MISS_MAX);

    // Framing FSM: hunt for frame_sync, then deserialise, check alignment and expand codes.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        ch_cnt_d    = ch_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        pcm_valid_d = 1'b0;
        pcm_out_d   = pcm_out_q;
        pcm_ch_d    = pcm_ch_q;
        code_out_d  = code_out_q;
        slip_err_d  = 1'b0;

        case (state_q)
            HUNT: begin
                if (bit_en && frame_sync) begin
                    state_d    = LOCK;
                    shreg_d    = {6'b0, bit_in};
                    bit_cnt_d  = 3'd1;
                    ch_cnt_d   = '0;
                    miss_cnt_d = 3'd0;
                end
            end
            LOCK: begin
                if (bit_en) begin
                    if (frame_sync && !at_sync_pt) begin
                        // Misplaced sync: drop the partial word and realign on this bit.
                        slip_err_d = 1'b1;
                        shreg_d    = {6'b0, bit_in};
                        bit_cnt_d  = 3'd1;
                        ch_cnt_d   = '0;
                        miss_cnt_d = 3'd0;
                    end else if (at_sync_pt && !frame_sync && miss_limit) begin
                        // Too many missing syncs: give up lock and discard this bit.
                        state_d    = HUNT;
                        shreg_d    = 7'd0;
                        bit_cnt_d  = 3'd0;
                        ch_cnt_d   = '0;
                        miss_cnt_d = 3'd0;
                    end else begin
                        if (at_sync_pt) begin
                            miss_cnt_d = frame_sync ? 3'd0 : (miss_cnt_q + 3'd1);
                        end
                        shreg_d = word_raw[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d   = 3'd0;
                            ch_cnt_d    = (ch_cnt_q == CH_W'(NUM_CH - 1)) ? '0 : (ch_cnt_q + CH_W'(1));
                            pcm_valid_d = 1'b1;
                            pcm_out_d   = word_lin[12 -: OUT_W];
                            pcm_ch_d    = ch_cnt_q;
                            code_out_d  = word_code;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        locked_d = (state_d == LOCK);
    end

    // State and output registers; reset clears everything and returns to HUNT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            shreg_q     <= 7'd0;
            bit_cnt_q   <= 3'd0;
            ch_cnt_q    <= '0;
            miss_cnt_q  <= 3'd0;
            pcm_valid_q <= 1'b0;
            pcm_out_q   <= '0;
            pcm_ch_q    <= '0;
            code_out_q  <= 8'd0;
            locked_q    <= 1'b0;
            slip_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            ch_cnt_q    <= ch_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            pcm_valid_q <= pcm_valid_d;
            pcm_out_q   <= pcm_out_d;
            pcm_ch_q    <= pcm_ch_d;
            code_out_q  <= code_out_d;
            locked_q    <= locked_d;
            slip_err_q  <= slip_err_d;
        end
    end

    assign pcm_valid = pcm_valid_q;
    assign pcm_out   = pcm_out_q;
    assign pcm_ch    = pcm_ch_q;
    assign code_out  = code_out_q;
    assign locked    = locked_q;
    assign slip_err  = slip_err_q;

endmodule

// File: tb/tb_pcm_tdm_decoder.sv
// Directed testbench for pcm_tdm_decoder: an OUT_W=8 instance and an OUT_W=13 instance
// are driven from the same serial stream.
module tb_pcm_tdm_decoder;

`ifdef ALAW_EVEN_INVERT_EN
    localparam logic [7:0]  INV_MASK = 8'h55;
    localparam logic [7:0]  D5_CODE  = 8'h80;
    localparam logic [7:0]  D5_OUT8  = 8'h80;
    localparam logic [12:0] D5_OUT13 = 13'h1001;
`else
    localparam logic [7:0]  INV_MASK = 8'h00;
    localparam logic [7:0]  D5_CODE  = 8'hD5;
    localparam logic [7:0]  D5_OUT8  = 8'h95;
    localparam logic [12:0] D5_OUT13 = 13'h12B0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bit_en = 1'b0;
    logic bit_in = 1'b0;
    logic frame_sync = 1'b0;

    logic        pcm_valid, locked, slip_err;
    logic [7:0]  pcm_out;
    logic [1:0]  pcm_ch;
    logic [7:0]  code_out;
    logic        v13, locked13, slip13;
    logic [12:0] out13;
    logic [1:0]  ch13;
    logic [7:0]  code13;

    int checks = 0;
    int errors = 0;

    pcm_tdm_decoder #(.NUM_CH(4), .OUT_W(8), .SYNC_MISS_MAX(2)) dut8 (
        .clk(clk), .rst(rst), .bit_en(bit_en), .bit_in(bit_in), .frame_sync(frame_sync),
        .pcm_valid(pcm_valid), .pcm_out(pcm_out), .pcm_ch(pcm_ch), .code_out(code_out),
        .locked(locked), .slip_err(slip_err)
    );

    pcm_tdm_decoder #(.NUM_CH(4), .OUT_W(13), .SYNC_MISS_MAX(2)) dut13 (
        .clk(clk), .rst(rst), .bit_en(bit_en), .bit_in(bit_in), .frame_sync(frame_sync),
        .pcm_valid(v13), .pcm_out(out13), .pcm_ch(ch13), .code_out(code13),
        .locked(locked13), .slip_err(slip13)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one bit for one active edge; returns 1 time unit after that edge.
    task automatic send_bit(input logic b, input logic fs);
        @(negedge clk);
        bit_en     = 1'b1;
        bit_in     = b;
        frame_sync = fs;
        @(posedge clk);
        #1;
        bit_en     = 1'b0;
        frame_sync = 1'b0;
    endtask

    // Send an 8-bit word MSB first, optionally with frame_sync on the MSB and idle gaps between bits.
    // Reports pcm_valid pulses seen before the eighth bit and slip_err activity.
    task automatic send_word(input logic [7:0] raw, input logic fs, input int gap,
                             output int early, output int slips, output logic first_slip);
        early = 0;
        slips = 0;
        first_slip = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(raw[i], fs && (i == 7));
            if (i == 7) first_slip = slip_err;
            if (slip_err) slips++;
            if (i != 0 && pcm_valid) early++;
            if (i != 0 && gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", pcm_valid); end
        checks++; if (pcm_out !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", pcm_out); end
        checks++; if (pcm_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", pcm_ch); end
        checks++; if (code_out !== 8'h00) begin errors++; $display("FAIL reset_code got %h exp 00", code_out); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b exp 0", locked); end
        checks++; if (slip_err !== 1'b0) begin errors++; $display("FAIL reset_slip got %0b exp 0", slip_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_hunt_ignore();
        int e, s; logic f;
        send_word(8'hA5, 1'b0, 0, e, s, f);
        checks++; if (e !== 0 || pcm_valid !== 1'b0) begin errors++; $display("FAIL hunt_valid got %0d/%0b exp 0/0", e, pcm_valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL hunt_locked got %0b exp 0", locked); end
    endtask

    task automatic test_decode();
        logic [7:0]  codes [4] = '{8'h00, 8'hFF, 8'h35, 8'h90};
        logic [7:0]  exp8  [4] = '{8'h00, 8'hFE, 8'h05, 8'h81};
        logic [12:0] exp13 [4] = '{13'h0001, 13'h1FC0, 13'h00AC, 13'h1021};
        int e, s; logic f;
        for (int k = 0; k < 4; k++) begin
            send_word(codes[k] ^ INV_MASK, k == 0, (k == 2) ? 2 : 0, e, s, f);
            checks++; if (e !== 0) begin errors++; $display("FAIL decode_early%0d got %0d exp 0", k, e); end
            checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL decode_valid%0d got %0b exp 1", k, pcm_valid); end
            checks++; if (pcm_out !== exp8[k]) begin errors++; $display("FAIL decode_out8_%0d got %h exp %h", k, pcm_out, exp8[k]); end
            checks++; if (out13 !== exp13[k]) begin errors++; $display("FAIL decode_out13_%0d got %h exp %h", k, out13, exp13[k]); end
            checks++; if (pcm_ch !== 2'(k)) begin errors++; $display("FAIL decode_ch%0d got %0d exp %0d", k, pcm_ch, k); end
            checks++; if (code_out !== codes[k]) begin errors++; $display("FAIL decode_code%0d got %h exp %h", k, code_out, codes[k]); end
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL decode_locked%0d got %0b exp 1", k, locked); end
        end
        @(posedge clk); #1;
        checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL decode_pulse got %0b exp 0", pcm_valid); end
    endtask

    task automatic test_slip();
        int e, s; logic f;
        logic [7:0] part = 8'hE0;
        send_word(8'h35 ^ INV_MASK, 1'b1, 0, e, s, f);
        send_word(8'hFF ^ INV_MASK, 1'b0, 0, e, s, f);
        for (int i = 7; i >= 5; i--) begin
            send_bit(part[i], 1'b0);
        end
        send_word(8'h90 ^ INV_MASK, 1'b1, 0, e, s, f);
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL slip_pulse got %0b exp 1", f); end
        checks++; if (s !== 1) begin errors++; $display("FAIL slip_count got %0d exp 1", s); end
        checks++; if (e !== 0) begin errors++; $display("FAIL slip_no_ch2 got %0d exp 0", e); end
        checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL slip_valid got %0b exp 1", pcm_valid); end
        checks++; if (pcm_ch !== 2'd0) begin errors++; $display("FAIL slip_ch got %0d exp 0", pcm_ch); end
        checks++; if (pcm_out !== 8'h81) begin errors++; $display("FAIL slip_out got %h exp 81", pcm_out); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL slip_locked got %0b exp 1", locked); end
    endtask

    task automatic test_sync_loss();
        logic [7:0] codes [4] = '{8'h00, 8'hFF, 8'h35, 8'h90};
        int e, s; logic f;
        for (int k = 1; k < 4; k++) begin
            send_word(codes[k] ^ INV_MASK, 1'b0, 0, e, s, f);
        end
        for (int k = 0; k < 4; k++) begin
            send_word(codes[k] ^ INV_MASK, 1'b0, 0, e, s, f);
            checks++; if (pcm_valid !== 1'b1 || pcm_ch !== 2'(k)) begin errors++; $display("FAIL miss1_word%0d got %0b/%0d exp 1/%0d", k, pcm_valid, pcm_ch, k); end
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL miss1_locked%0d got %0b exp 1", k, locked); end
        end
        send_bit(1'b1, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL miss2_locked got %0b exp 0", locked); end
        checks++; if (pcm_out !== 8'h81) begin errors++; $display("FAIL miss2_hold got %h exp 81", pcm_out); end
        for (int k = 0; k < 2; k++) begin
            send_word(8'h5A, 1'b0, 0, e, s, f);
            checks++; if (e !== 0 || pcm_valid !== 1'b0) begin errors++; $display("FAIL miss2_novalid%0d got %0d/%0b exp 0/0", k, e, pcm_valid); end
        end
    endtask

    task automatic test_reset_midword();
        int e, s; logic f;
        logic [7:0] part = 8'hB0;
        send_word(8'hFF ^ INV_MASK, 1'b1, 0, e, s, f);
        checks++; if (pcm_out !== 8'hFE) begin errors++; $display("FAIL rstmid_pre got %h exp fe", pcm_out); end
        for (int i = 7; i >= 4; i--) begin
            send_bit(part[i], 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (pcm_out !== 8'h00 || code_out !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h/%h exp 00/00", pcm_out, code_out); end
        checks++; if (locked !== 1'b0 || pcm_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl got %0b/%0b exp 0/0", locked, pcm_valid); end
        @(negedge clk);
        rst = 1'b0;
        send_word(8'h35, 1'b0, 0, e, s, f);
        checks++; if (e !== 0 || pcm_valid !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL rstmid_hunt got %0d/%0b/%0b exp 0/0/0", e, pcm_valid, locked); end
        send_word(8'h35 ^ INV_MASK, 1'b1, 0, e, s, f);
        checks++; if (pcm_valid !== 1'b1 || pcm_ch !== 2'd0) begin errors++; $display("FAIL rstmid_resync got %0b/%0d exp 1/0", pcm_valid, pcm_ch); end
        checks++; if (pcm_out !== 8'h05) begin errors++; $display("FAIL rstmid_out got %h exp 05", pcm_out); end
    endtask

    task automatic test_invert();
        int e, s; logic f;
        send_word(8'hD5, 1'b0, 0, e, s, f);
        checks++; if (pcm_valid !== 1'b1 || pcm_ch !== 2'd1) begin errors++; $display("FAIL inv_valid got %0b/%0d exp 1/1", pcm_valid, pcm_ch); end
        checks++; if (code_out !== D5_CODE) begin errors++; $display("FAIL inv_code got %h exp %h", code_out, D5_CODE); end
        checks++; if (pcm_out !== D5_OUT8) begin errors++; $display("FAIL inv_out8 got %h exp %h", pcm_out, D5_OUT8); end
        checks++; if (out13 !== D5_OUT13) begin errors++; $display("FAIL inv_out13 got %h exp %h", out13, D5_OUT13); end
    endtask

    initial begin
        test_reset();
        test_hunt_ignore();
        test_decode();
        test_slip();
        test_sync_loss();
        test_reset_midword();
        test_invert();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
